serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares a single 1-bit full-adder cell across a WIDTH-bit operation. It sequences one bit per clock from LSB to MSB and holds the carry between cycles in a flip-flop. It handles start/busy/done handshaking with the requester. It sits between a register-level requester and the gate-level adder cell, and trades WIDTH cycles of latency for one adder's worth of area.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/fa_nand.sv | 22 ++
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_nand.sv
// One-bit full adder built only from 2-input NAND gates (nine-gate form).
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_n1, w_n2, w_n3, w_x1, w_n4, w_n5, w_n6;

  assign w_n1 = ~(a & b);
  assign w_n2 = ~(a & w_n1);
  assign w_n3 = ~(b & w_n1);
  assign w_x1 = ~(w_n2 & w_n3);   // a ^ b
  assign w_n4 = ~(w_x1 & ci);
  assign w_n5 = ~(w_x1 & w_n4);
  assign w_n6 = ~(ci & w_n4);
  assign s    = ~(w_n5 & w_n6);
  assign co   = ~(w_n4 & w_n1);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one shared full-adder cell walks the operands LSB
// first, one bit per clock, with start/busy/done handshaking.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf;
  logic             w_accept, w_last, w_sum, w_co;
  logic [WIDTH-1:0] w_res_next;

  // start is only honoured when no operation is in flight.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == LAST);

  fa_nand u_cell (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_sum;
    end else begin : g_res_wn
      assign w_res_next = {w_sum, r_result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so only the B load and carry-in differ.
      r_a      <= a;
      r_b      <= sub ? ~b : b;
      r_carry  <= sub | cin;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_carry  <= w_co;
      r_result <= w_res_next;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= r_carry ^ w_co;  // r_carry is the carry into the MSB here
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) using a queue scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic ts, input logic tc);
    logic [W-1:0] bb;
    logic [W:0]   s;
    exp_t         e;
    bb   = ts ? ~tb : tb;
    s    = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, (ts | tc)};
    e.res = s[W-1:0];
    e.co  = s[W];
    e.ov  = (ta[W-1] == bb[W-1]) && (s[W-1] != ta[W-1]);
    return e;
  endfunction

  // Drives a request for the coming edge and records its expected outcome.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tc);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    sb.push_back(model(ta, tb, ts, tc));
  endtask

  // Counts cycles (current cycle = 1) until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b0; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_add;
    logic [W-1:0] va[5] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h00};
    logic [W-1:0] vb[5] = '{8'h3C, 8'h01, 8'h01, 8'h7F, 8'h00};
    logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) launch(va[i], vb[i], 1'b0, vc[i]);
      else launch(8'($urandom), 8'($urandom), 1'b0, 1'($urandom));
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %b want 1", busy); end
      wait_done(n);
      checks++; if (n != W + 1) begin errors++; $display("FAIL add_latency got %0d want %0d", n, W + 1); end
      e = sb.pop_front();
      checks++; if (result !== e.res) begin errors++; $display("FAIL add_result got %h want %h", result, e.res); end
      checks++; if (cout !== e.co) begin errors++; $display("FAIL add_cout got %b want %b", cout, e.co); end
      checks++; if (ovf !== e.ov) begin errors++; $display("FAIL add_ovf got %b want %b", ovf, e.ov); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done got %b want 0", busy); end
      $display("add a=%h b=%h cin=%b -> result=%h cout=%b ovf=%b", a, b, cin, result, cout, ovf);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL add_hold got %h want %h", result, e.res); end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] va[3] = '{8'h10, 8'h80, 8'h00};
    logic [W-1:0] vb[3] = '{8'h20, 8'h01, 8'h00};
    int n;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      // cin is set high to show it has no effect in subtract mode
      if (i < 3) launch(va[i], vb[i], 1'b1, 1'b1);
      else launch(8'($urandom), 8'($urandom), 1'b1, 1'($urandom));
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      checks++; if (n != W + 1) begin errors++; $display("FAIL sub_latency got %0d want %0d", n, W + 1); end
      e = sb.pop_front();
      checks++; if (result !== e.res) begin errors++; $display("FAIL sub_result got %h want %h", result, e.res); end
      checks++; if (cout !== e.co) begin errors++; $display("FAIL sub_cout got %b want %b", cout, e.co); end
      checks++; if (ovf !== e.ov) begin errors++; $display("FAIL sub_ovf got %b want %b", ovf, e.ov); end
      $display("sub a=%h b=%h -> result=%h cout=%b ovf=%b", a, b, result, cout, ovf);
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    exp_t e;
    launch(8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    a = 8'h11; b = 8'h22; sub = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;  // cycle 3 of RUN, not recorded: must be ignored
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
    n = 4;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != W + 1) begin errors++; $display("FAIL ignore_latency got %0d want %0d", n, W + 1); end
    e = sb.pop_front();
    checks++; if (result !== e.res) begin errors++; $display("FAIL ignore_result got %h want %h", result, e.res); end
    checks++; if (ovf !== e.ov) begin errors++; $display("FAIL ignore_ovf got %b want %b", ovf, e.ov); end
    $display("ignore-start op -> result=%h cout=%b ovf=%b", result, cout, ovf);
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int n;
    int seen;
    exp_t e;
    a = 8'hF0; b = 8'h0F; sub = 1'b0; cin = 1'b1; start = 1'b1;  // aborted: not scored
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result got %h want 00", result); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL abort_flags got %b want 00", {cout, ovf}); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    launch(8'h80, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL after_abort_latency got %0d want %0d", n, W + 1); end
    e = sb.pop_front();
    checks++; if ({result, cout, ovf} !== {e.res, e.co, e.ov}) begin
      errors++; $display("FAIL after_abort_op got %h/%b/%b want %h/%b/%b", result, cout, ovf, e.res, e.co, e.ov);
    end
    $display("post-abort op -> result=%h cout=%b ovf=%b", result, cout, ovf);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    exp_t e;
    launch(8'hFF, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    // start stays high; next operands are what the DONE-cycle edge accepts
    launch(8'h10, 8'h20, 1'b1, 1'b0);
    wait_done(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", n, W + 1); end
    e = sb.pop_front();
    checks++; if ({result, cout, ovf} !== {e.res, e.co, e.ov}) begin
      errors++; $display("FAIL b2b_first got %h/%b/%b want %h/%b/%b", result, cout, ovf, e.res, e.co, e.ov);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_exclusive got busy %b with done", busy); end
    $display("b2b op1 -> result=%h cout=%b ovf=%b", result, cout, ovf);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
    wait_done(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", n, W + 1); end
    e = sb.pop_front();
    checks++; if ({result, cout, ovf} !== {e.res, e.co, e.ov}) begin
      errors++; $display("FAIL b2b_second got %h/%b/%b want %h/%b/%b", result, cout, ovf, e.res, e.co, e.ov);
    end
    $display("b2b op2 -> result=%h cout=%b ovf=%b", result, cout, ovf);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
